// File: rtl/loop_unrll_ctrl.sv
// Loop-unroll sequencer: replays a short backward-branch loop body UNRLL_FACTOR-1 extra times.
// Define LOOP_UNRLL_STATS_EN to add unrll_cnt_out, a saturating count of completed unrolls.
module loop_unrll_ctrl #(
  parameter int UNRLL_FACTOR = 4,
  parameter int MAX_BODY     = 16,
  parameter int ITER_W       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid_in,
  input  logic              bck_lp_in,
  input  logic              pred_result_in,
  input  logic [15:0]       cur_PC_in,
  input  logic [15:0]       tgt_PC_in,
  input  logic              stall_in,
  input  logic              flush_in,
  output logic              unrll_act_out,
  output logic [15:0]       fetch_PC_out,
  output logic              fetch_vld_out,
  output logic              fnsh_unrll_out,
  output logic [ITER_W-1:0] unrll_iter_out
`ifdef LOOP_UNRLL_STATS_EN
  ,
  output logic [15:0]       unrll_cnt_out
`endif
);

  typedef enum logic {IDLE, REPLAY} state_e;

  localparam logic [15:0]       MAX_LEN   = 16'(MAX_BODY);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(UNRLL_FACTOR - 1);
  localparam logic [ITER_W-1:0] FULL_ITER = ITER_W'(UNRLL_FACTOR);

  state_e            state_q, state_d;
  logic [15:0]       lp_start_q, lp_start_d;
  logic [15:0]       lp_end_q, lp_end_d;
  logic [15:0]       ptr_q, ptr_d;
  logic [15:0]       last_pc_q, last_pc_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              squash_q, squash_d;

  logic [15:0] body_len;
  logic        len_ok;
  logic        trig;
  logic        at_end;
  logic        last_copy;
  logic        in_replay;

  assign body_len  = cur_PC_in - tgt_PC_in + 16'd1;
  assign len_ok    = (body_len != 16'd0) && (body_len <= MAX_LEN);
  assign in_replay = (state_q == REPLAY);
  assign trig      = !in_replay && inst_valid_in && bck_lp_in && pred_result_in &&
                     !stall_in && !flush_in && len_ok;
  assign at_end    = (ptr_q == lp_end_q);
  assign last_copy = (iter_q == LAST_ITER);

  // NOTE: every _d gets its current value first, so no path through the
  // case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    lp_start_d = lp_start_q;
    lp_end_d   = lp_end_q;
    ptr_d      = ptr_q;
    last_pc_d  = last_pc_q;
    iter_d     = iter_q;
    squash_d   = squash_q;
    if (flush_in) begin
      state_d  = IDLE;
      squash_d = 1'b0;
      iter_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (trig) begin
            state_d    = REPLAY;
            lp_start_d = tgt_PC_in;
            lp_end_d   = cur_PC_in;
            ptr_d      = tgt_PC_in;
            last_pc_d  = tgt_PC_in;
            iter_d     = ITER_W'(1);
          end
        end
        REPLAY: begin
          if (!stall_in) begin
            last_pc_d = ptr_q;
            if (!at_end) begin
              ptr_d    = ptr_q + 16'd1;
              squash_d = 1'b0;
            end else if (!last_copy) begin
              // Interior copy end: its back-branch reaches decode next cycle and is squashed.
              squash_d = 1'b1;
              iter_d   = iter_q + ITER_W'(1);
              ptr_d    = lp_start_q;
            end else begin
              squash_d = 1'b0;
              iter_d   = FULL_ITER;
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lp_start_q <= '0;
      lp_end_q   <= '0;
      ptr_q      <= '0;
      last_pc_q  <= '0;
      iter_q     <= '0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lp_start_q <= lp_start_d;
      lp_end_q   <= lp_end_d;
      ptr_q      <= ptr_d;
      last_pc_q  <= last_pc_d;
      iter_q     <= iter_d;
      squash_q   <= squash_d;
    end
  end

  always_comb begin
    unrll_act_out  = in_replay;
    fetch_vld_out  = in_replay && !stall_in && !flush_in;
    fnsh_unrll_out = !flush_in && (trig || squash_q);
    unrll_iter_out = iter_q;
    fetch_PC_out   = '0;
    // While stalled the fetch bus keeps showing the last PC actually issued.
    if (in_replay) fetch_PC_out = stall_in ? last_pc_q : ptr_q;
  end

`ifdef LOOP_UNRLL_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  logic        cmpl;

  assign cmpl = in_replay && !stall_in && !flush_in && at_end && last_copy;

  always_comb begin
    cnt_d = cnt_q;
    if (cmpl && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign unrll_cnt_out = cnt_q;
`else
  // Statistics counter not built.
`endif

endmodule
